// File: rtl/sdrc_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdrc_chk_pkg
// Brief    : Shared types and helpers for the SDRAM address-map checker:
//            command enum, queued request entry, column-width helpers.
// Revision : 1.0 - initial release
// ============================================================================
package sdrc_chk_pkg;

    // Entry field widths; the row field is always 13 bits because the
    // app-address row slice is addr[C+14:C+2] regardless of column width.
    localparam int c_ROW_W  = 13;
    localparam int c_BANK_W = 2;
    localparam int c_COL_W  = 11;
    localparam int c_LEN_W  = 9;
    localparam int c_CB_W   = 2;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4
    } cmd_e;

    typedef struct packed {
        logic [c_ROW_W-1:0]  row;
        logic [c_BANK_W-1:0] bank;
        logic [c_COL_W-1:0]  col;
        logic                wr;
        logic [c_LEN_W-1:0]  len;
        logic [c_CB_W-1:0]   colbits;
    } req_ent_t;

    // Number of column bits selected by the 2-bit configuration code.
    function automatic logic [3:0] col_width(input logic [c_CB_W-1:0] colbits);
        return 4'd8 + {2'b00, colbits};
    endfunction

    // Mask keeping only the active column bits for a configuration code.
    function automatic logic [c_COL_W-1:0] col_mask(input logic [c_CB_W-1:0] colbits);
        logic [c_COL_W-1:0] m;
        case (colbits)
            2'b00:   m = 11'h0FF;
            2'b01:   m = 11'h1FF;
            2'b10:   m = 11'h3FF;
            default: m = 11'h7FF;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdrc_chk_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sdrc_chk_fifo
// Brief    : DEPTH-entry synchronous FIFO of decoded request entries with
//            first-word fall-through head, full/empty flags and occupancy.
//            The caller guarantees no push when full without a pop and no
//            pop when empty.
// Revision : 1.0 - initial release
// ============================================================================
module sdrc_chk_fifo
    import sdrc_chk_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  req_ent_t               i_data,
    input  logic                   i_pop,
    output req_ent_t               o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL_LVL = (c_PTR_W+1)'(DEPTH);

    req_ent_t             r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_level;

    // Storage array; contents need no reset since occupancy gates their use.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_level == c_FULL_LVL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/sdrc_addr_map_checker.sv
`default_nettype none
// ============================================================================
// Module   : sdrc_addr_map_checker
// Brief    : Scoreboard checker for the SDRAM controller address mapper.
//            Queues accepted app requests, decodes expected {row,bank,col},
//            and checks every READ/WRITE on the SDRAM pins against the queue
//            head. Optional open-row tracking is enabled by defining
//            ADDR_CHK_ROW_EN; without it err_row is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module sdrc_addr_map_checker
    import sdrc_chk_pkg::*;
#(
    parameter int APP_AW   = 26,
    parameter int SDR_AW   = 13,
    parameter int BA_W     = 2,
    parameter int DEPTH    = 8,
    parameter int LEN_W    = 9,
    parameter int COL_STEP = 4,
    parameter int CNT_W    = 16
) (
    input  logic                   sdram_clk,
    input  logic                   sdram_rst,
    input  logic [1:0]             cfg_colbits,
    input  logic                   req_valid,
    input  logic                   req_wr,
    input  logic [APP_AW-1:0]      req_addr,
    input  logic [LEN_W-1:0]       req_len,
    input  logic                   sdr_cs_n,
    input  logic                   sdr_ras_n,
    input  logic                   sdr_cas_n,
    input  logic                   sdr_we_n,
    input  logic [BA_W-1:0]        sdr_ba,
    input  logic [SDR_AW-1:0]      sdr_addr,
    output logic                   chk_ok,
    output logic                   err_col,
    output logic                   err_bank,
    output logic                   err_row,
    output logic                   err_dir,
    output logic                   err_unexp,
    output logic                   err_ovf,
    output logic [CNT_W-1:0]       match_cnt,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [$clog2(DEPTH):0] q_level
);

    localparam int c_NBANK = 1 << BA_W;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    cmd_e w_cmd;

    // Translate the SDRAM command pins into a command class.
    always_comb begin
        w_cmd = CMD_NOP;
        if (!sdr_cs_n) begin
            case ({sdr_ras_n, sdr_cas_n, sdr_we_n})
                3'b011:  w_cmd = CMD_ACT;
                3'b101:  w_cmd = CMD_RD;
                3'b100:  w_cmd = CMD_WR;
                3'b010:  w_cmd = CMD_PRE;
                default: w_cmd = CMD_NOP;
            endcase
        end
    end

    logic w_is_col;
    assign w_is_col = (w_cmd == CMD_RD) || (w_cmd == CMD_WR);

    // ------------------------------------------------------------------
    // Request decode at push time, using this cycle's column setting
    // ------------------------------------------------------------------
    logic [APP_AW-1:0] w_addr_sh;
    req_ent_t          w_push_ent;

    assign w_addr_sh = req_addr >> col_width(cfg_colbits);

    // Split the app address into row/bank/col for the active column width.
    always_comb begin
        w_push_ent.row     = w_addr_sh[c_BANK_W +: c_ROW_W];
        w_push_ent.bank    = w_addr_sh[c_BANK_W-1:0];
        w_push_ent.col     = req_addr[c_COL_W-1:0] & col_mask(cfg_colbits);
        w_push_ent.wr      = req_wr;
        w_push_ent.len     = c_LEN_W'(req_len);
        w_push_ent.colbits = cfg_colbits;
    end

    // ------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------
    req_ent_t w_head;
    logic     w_full;
    logic     w_empty;
    logic     w_push;
    logic     w_pop;
    logic     w_last;
    logic     w_chk;
    logic     w_ovf_evt;
    logic [c_LEN_W-1:0] r_k;

    // A zero length counts as a single column command.
    assign w_last    = (w_head.len == '0) || (r_k == (w_head.len - c_LEN_W'(1)));
    assign w_chk     = w_is_col && !w_empty;
    assign w_pop     = w_chk && w_last;
    // A pop in the same cycle frees the slot, so push is allowed even when full.
    assign w_push    = req_valid && (!w_full || w_pop);
    assign w_ovf_evt = req_valid && w_full && !w_pop;

    sdrc_chk_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (sdram_clk),
        .rst     (sdram_rst),
        .i_push  (w_push),
        .i_data  (w_push_ent),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (q_level)
    );

    // ------------------------------------------------------------------
    // Column comparison against the queue head
    // ------------------------------------------------------------------
    logic [31:0]         w_col_sum;
    logic [c_COL_W-1:0]  w_col_exp;
    logic [c_COL_W-1:0]  w_col_obs;
    logic                w_col_bad;
    logic                w_bank_bad;
    logic                w_row_bad;
    logic                w_dir_bad;
    logic                w_any_bad;

    assign w_col_sum = 32'(w_head.col) + 32'(r_k) * 32'(COL_STEP);
    assign w_col_exp = w_col_sum[c_COL_W-1:0] & col_mask(w_head.colbits);

    // With 11 column bits A10 carries auto-precharge, so col[10] rides on A11.
    always_comb begin
        if (w_head.colbits == 2'b11) begin
            w_col_obs = {sdr_addr[11], sdr_addr[9:0]};
        end else begin
            w_col_obs = sdr_addr[c_COL_W-1:0] & col_mask(w_head.colbits);
        end
    end

    assign w_col_bad  = (w_col_obs != w_col_exp);
    assign w_bank_bad = (c_BANK_W'(sdr_ba) != w_head.bank);
    assign w_dir_bad  = ((w_cmd == CMD_WR) != w_head.wr);
    assign w_any_bad  = w_col_bad || w_bank_bad || w_row_bad || w_dir_bad;

    // ------------------------------------------------------------------
    // Open-row tracking
    // ------------------------------------------------------------------
`ifdef ADDR_CHK_ROW_EN
    logic [SDR_AW-1:0]  r_open_row [c_NBANK];
    logic [c_NBANK-1:0] r_open_vld;

    // Record the row opened by ACTIVATE and forget it on PRECHARGE.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            r_open_vld <= '0;
            for (int i = 0; i < c_NBANK; i++) begin
                r_open_row[i] <= '0;
            end
        end else if (w_cmd == CMD_ACT) begin
            r_open_row[sdr_ba] <= sdr_addr;
            r_open_vld[sdr_ba] <= 1'b1;
        end else if (w_cmd == CMD_PRE) begin
            if (sdr_addr[10]) begin
                r_open_vld <= '0;
            end else begin
                r_open_vld[sdr_ba] <= 1'b0;
            end
        end
    end

    assign w_row_bad = !r_open_vld[sdr_ba] ||
                       (r_open_row[sdr_ba] != SDR_AW'(w_head.row));
`else
    logic w_unused_row;
    assign w_row_bad    = 1'b0;
    assign w_unused_row = ^{w_head.row, sdr_addr[SDR_AW-1:c_COL_W]};
`endif

    logic w_unused;
    assign w_unused = ^{w_addr_sh[APP_AW-1:c_BANK_W+c_ROW_W], w_col_sum[31:c_COL_W]};

    // ------------------------------------------------------------------
    // Registered result pulses, sticky flags and counters
    // ------------------------------------------------------------------
    logic w_unexp_evt;
    logic w_match_evt;
    logic w_err_evt;

    assign w_unexp_evt = w_is_col && w_empty;
    assign w_match_evt = w_chk && !w_any_bad;
    assign w_err_evt   = (w_chk && w_any_bad) || w_unexp_evt;

    logic             r_chk_ok;
    logic             r_err_col;
    logic             r_err_bank;
    logic             r_err_row;
    logic             r_err_dir;
    logic             r_err_unexp;
    logic             r_err_ovf;
    logic [CNT_W-1:0] r_match_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    // One-cycle result pulses, per-entry command index, sticky flags, counters.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            r_chk_ok    <= 1'b0;
            r_err_col   <= 1'b0;
            r_err_bank  <= 1'b0;
            r_err_row   <= 1'b0;
            r_err_dir   <= 1'b0;
            r_err_unexp <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_match_cnt <= '0;
            r_err_cnt   <= '0;
            r_k         <= '0;
        end else begin
            r_chk_ok   <= w_match_evt;
            r_err_col  <= w_chk && w_col_bad;
            r_err_bank <= w_chk && w_bank_bad;
            r_err_row  <= w_chk && w_row_bad;
            r_err_dir  <= w_chk && w_dir_bad;
            if (w_chk) begin
                r_k <= w_last ? '0 : r_k + 1'b1;
            end
            if (w_unexp_evt) begin
                r_err_unexp <= 1'b1;
            end
            if (w_ovf_evt) begin
                r_err_ovf <= 1'b1;
            end
            if (w_match_evt && (r_match_cnt != '1)) begin
                r_match_cnt <= r_match_cnt + 1'b1;
            end
            if (w_err_evt && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign chk_ok    = r_chk_ok;
    assign err_col   = r_err_col;
    assign err_bank  = r_err_bank;
    assign err_row   = r_err_row;
    assign err_dir   = r_err_dir;
    assign err_unexp = r_err_unexp;
    assign err_ovf   = r_err_ovf;
    assign match_cnt = r_match_cnt;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire
